// File: rtl/sha256_pkg.sv
// sha256_pkg
//   Shared definitions for the iterative SHA-256 compression core:
//   round-constant ROM, FSM state encoding and the SHA-256 boolean /
//   rotation helper functions used by the round datapath.
package sha256_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FINAL = 2'd1,
    DONE  = 2'd2
  } state_e;

  // FIPS 180-4 round constants, K[0] in the leftmost slot.
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    ror = (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    ch = (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    maj = (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    big_sigma0 = ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    big_sigma1 = ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round
//   Purely combinational SHA-256 compression round.
//   Ports:
//     state_i  [0:7][31:0]  working state a..h (a in slot 0)
//     k_i      [31:0]       round constant K[t]
//     w_i      [31:0]       schedule word W[t]
//     state_o  [0:7][31:0]  working state after the round
module sha256_round
  import sha256_pkg::*;
(
  input  logic [0:7][31:0] state_i,
  input  logic [31:0]      k_i,
  input  logic [31:0]      w_i,
  output logic [0:7][31:0] state_o
);

  logic [31:0] t1, t2;

  // All additions wrap mod 2^32 through the 32-bit result width.
  assign t1 = state_i[7] + big_sigma1(state_i[4])
            + ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
  assign t2 = big_sigma0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);

  assign state_o = {t1 + t2,            // a
                    state_i[0],         // b
                    state_i[1],         // c
                    state_i[2],         // d
                    state_i[3] + t1,    // e
                    state_i[4],         // f
                    state_i[5],         // g
                    state_i[6]};        // h

endmodule

// File: rtl/sha256_cnter.sv
// sha256_cnter
//   Iterative SHA-256 compression core, one round per clock. Reset release
//   starts a run over one block; done rises on the 65th posedge after release.
//   Ports:
//     clk    in   1             clock, posedge
//     reset  in   1             async active-high; release starts the run
//     H_in   in   [0:7][31:0]   chaining value, H_in[0] = a
//     W      in   [0:63][31:0]  expanded schedule, W[0] used in round 0
//     done   out  1             H_out valid, held until next reset
//     H_out  out  [255:0]       {H0',..,H7'}, H0' in [255:224]
module sha256_cnter
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [0:7][31:0]  H_in,
  input  logic [0:63][31:0] W,
  output logic              done,
  output logic [255:0]      H_out
);

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [6:0]       t_q, t_d;
  logic [0:7][31:0] work_q, work_d;
  logic             done_q, done_d;
  logic [255:0]     hout_q, hout_d;

  logic [0:7][31:0] rnd_in, rnd_out, sum;

  // The working registers reset to zero rather than loading H_in
  // asynchronously; round 0 takes its a..h straight from H_in instead,
  // which is equivalent and keeps the reset value a constant.
  assign rnd_in = (t_q == 7'd0) ? H_in : work_q;

  // t_q reaches 64 only outside RUN, where the round result is unused.
  sha256_round u_round (
    .state_i (rnd_in),
    .k_i     (K[t_q[5:0]]),
    .w_i     (W[t_q[5:0]]),
    .state_o (rnd_out)
  );

  always_comb begin
    for (int i = 0; i < 8; i++) sum[i] = H_in[i] + work_q[i];
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    work_d  = work_q;
    done_d  = done_q;
    hout_d  = hout_q;
    unique case (state_q)
      RUN: begin
        work_d = rnd_out;
        t_d    = t_q + 7'd1;
        if (t_q == LAST_T) state_d = FINAL;
      end
      FINAL: begin
        hout_d  = sum;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: ;
      default: state_d = DONE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      t_q     <= '0;
      work_q  <= '0;
      done_q  <= 1'b0;
      hout_q  <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      work_q  <= work_d;
      done_q  <= done_d;
      hout_q  <= hout_d;
    end
  end

  assign done  = done_q;
  assign H_out = hout_q;

endmodule

// File: tb/tb_sha256_cnter.sv
module tb_sha256_cnter;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [0:7][31:0]  H_in;
  logic [0:63][31:0] W;
  logic              done;
  logic [255:0]      H_out;

  int checks = 0;
  int errors = 0;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] DIG_ABC =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam logic [0:63][31:0] TK = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  sha256_cnter dut (
    .clk   (clk),
    .reset (reset),
    .H_in  (H_in),
    .W     (W),
    .done  (done),
    .H_out (H_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    rr = (x >> n) | (x << (32 - n));
  endfunction

  // Message schedule expansion (upstream block's job, rebuilt here).
  function automatic logic [0:63][31:0] expand(input logic [0:15][31:0] m);
    logic [0:63][31:0] w;
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    return w;
  endfunction

  // Reference compression for vectors without a published digest.
  function automatic logic [255:0] ref_compress(input logic [0:7][31:0] h,
                                                input logic [0:63][31:0] w);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  function automatic logic [0:63][31:0] sched_abc();
    logic [0:15][31:0] m = '0;
    m[0] = 32'h61626380;
    m[15] = 32'h00000018;
    return expand(m);
  endfunction

  function automatic logic [0:63][31:0] sched_empty();
    logic [0:15][31:0] m = '0;
    m[0] = 32'h80000000;
    return expand(m);
  endfunction

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Counts posedges after release until done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done && n < 200);
  endtask

  task automatic test_reset();
    H_in  = IV;
    W     = sched_abc();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL reset_done cyc%0d: got %b want 0", c, done);
      end
      checks++;
      if (H_out !== 256'd0) begin
        errors++;
        $display("FAIL reset_hout cyc%0d: got %h want 0", c, H_out);
      end
    end
  endtask

  task automatic test_abc();
    int n;
    H_in = IV;
    W    = sched_abc();
    apply_reset(2);
    wait_done(n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL abc_latency: got %0d want 65", n);
    end
    checks++;
    if (H_out !== DIG_ABC) begin
      errors++;
      $display("FAIL abc_digest: got %h want %h", H_out, DIG_ABC);
    end
  endtask

  task automatic test_latency_hold();
    logic early = 1'b0;
    H_in = IV;
    W    = sched_abc();
    apply_reset(2);
    for (int e = 1; e <= 64; e++) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: got done before edge 65 want low");
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge65: got %b want 1", done);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || H_out !== DIG_ABC) begin
        errors++;
        $display("FAIL hold cyc%0d: got done=%b %h want done=1 %h", c, done, H_out, DIG_ABC);
      end
    end
  endtask

  task automatic test_empty();
    int n;
    H_in = IV;
    W    = sched_empty();
    apply_reset(1);
    wait_done(n);
    checks++;
    if (n !== 65 || H_out !== DIG_EMPTY) begin
      errors++;
      $display("FAIL empty_digest: got n=%0d %h want n=65 %h", n, H_out, DIG_EMPTY);
    end
  endtask

  task automatic test_midrun_reset();
    int n;
    H_in = IV;
    W    = sched_empty();
    apply_reset(1);
    wait_done(n);   // leave a completed digest behind first
    W    = sched_abc();
    apply_reset(1);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || H_out !== 256'd0) begin
      errors++;
      $display("FAIL midrun_clear: got done=%b %h want done=0 0", done, H_out);
    end
    apply_reset(2);
    wait_done(n);
    checks++;
    if (n !== 65) begin
      errors++;
      $display("FAIL midrun_latency: got %0d want 65", n);
    end
    checks++;
    if (H_out !== DIG_ABC) begin
      errors++;
      $display("FAIL midrun_digest: got %h want %h", H_out, DIG_ABC);
    end
  endtask

  task automatic test_all_ones();
    int n;
    logic [255:0] exp_ref;
    exp_ref = ref_compress(IV, sched_abc());
    checks++;
    if (exp_ref !== DIG_ABC) begin
      errors++;
      $display("FAIL refmodel_abc: got %h want %h", exp_ref, DIG_ABC);
    end
    H_in = {8{32'hffffffff}};
    W    = '0;
    exp_ref = ref_compress(H_in, W);
    apply_reset(1);
    wait_done(n);
    checks++;
    if (n !== 65 || H_out !== exp_ref) begin
      errors++;
      $display("FAIL all_ones: got n=%0d %h want n=65 %h", n, H_out, exp_ref);
    end
  endtask

  initial begin
    H_in = '0;
    W    = '0;
    test_reset();
    test_abc();
    test_latency_hold();
    test_empty();
    test_midrun_reset();
    test_all_ones();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
